// File: rtl/dijkstra_path_extractor.sv
// -----------------------------------------------------------------------------
// dijkstra_path_extractor
//
// Purpose:
//   Sits behind the Dijkstra core. After a run, walks the predecessor memory
//   from the destination node back to the source node and stores the visited
//   nodes in a small path buffer. The host interface reads the buffered path
//   by index together with its length.
//
// Optional feature (compile-time macro):
//   PATH_SOURCE_FIRST_EN  defined   : path_index 0 = source, last = destination
//                         undefined : path_index 0 = destination (walk order)
//   Timing, length and error behaviour are identical in both builds.
//
// Handshake:
//   start is a one-cycle pulse accepted in IDLE, DONE or FAIL and ignored
//   while a walk is in progress (READ/CHECK). ready is a level that rises
//   when the walk ends and stays high until the next accepted start; error
//   qualifies the result and is only meaningful while ready=1. pred_rd is a
//   single-cycle read strobe; pred_rdata must be valid the following cycle.
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   asynchronous, active-high
//   start            in   begin extraction (1-cycle pulse)
//   source           in   start node of the Dijkstra run
//   destination      in   end node; the walk begins here
//   number_of_nodes  in   node count of the current graph (17 bits)
//   pred_addr        out  predecessor memory read address
//   pred_rd          out  predecessor memory read strobe
//   pred_rdata       in   predecessor of the node at pred_addr
//   path_index       in   read-out index into the stored path
//   path_node        out  node at path_index (combinational from the buffer)
//   path_length      out  number of stored nodes, both ends included
//   ready            out  extraction finished (success or error)
//   error            out  path invalid; valid while ready=1
//   state_dbg        out  current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module dijkstra_path_extractor #(
    parameter int MAX_NODES  = 32,
    parameter int NODE_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NODE_WIDTH-1:0] source,
    input  logic [NODE_WIDTH-1:0] destination,
    input  logic [16:0]           number_of_nodes,
    output logic [NODE_WIDTH-1:0] pred_addr,
    output logic                  pred_rd,
    input  logic [NODE_WIDTH-1:0] pred_rdata,
    input  logic [NODE_WIDTH-1:0] path_index,
    output logic [NODE_WIDTH-1:0] path_node,
    output logic [NODE_WIDTH-1:0] path_length,
    output logic                  ready,
    output logic                  error,
    output logic [2:0]            state_dbg
);

    localparam int AW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
    localparam logic [NODE_WIDTH-1:0] NO_PRED = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    state_t                state;
    logic [NODE_WIDTH-1:0] src_q;
    logic [16:0]           n_q;

    logic [NODE_WIDTH-1:0] path_buf [MAX_NODES];

    logic                  accept;
    logic                  start_bad;
    logic                  pred_none;
    logic                  buf_full;
    logic                  buf_we;
    logic [AW-1:0]         buf_waddr;
    logic [NODE_WIDTH-1:0] buf_wdata;
    logic [AW-1:0]         rd_sel;

    assign state_dbg = state;

    // A new start is taken whenever no walk is in progress.
    assign accept = start && (state == S_IDLE || state == S_DONE || state == S_FAIL);

    // Compared at 32 bits so the 17-bit count and node indices line up
    // without truncation.
    assign start_bad = (32'(source) >= 32'(number_of_nodes)) ||
                       (32'(destination) >= 32'(number_of_nodes)) ||
                       (32'(number_of_nodes) > 32'(MAX_NODES)) ||
                       (number_of_nodes == 17'd0);

    assign pred_none = (pred_rdata == NO_PRED);

    // Once as many nodes as the graph holds are stored, another predecessor
    // can only mean a loop in the predecessor table.
    assign buf_full  = (32'(path_length) == 32'(n_q));

    // Buffer write port: destination on an accepted start, each new
    // predecessor while walking. path_length is always below n_q <= MAX_NODES
    // at a write, so its low AW bits address the buffer directly.
    always_comb begin
        buf_we    = 1'b0;
        buf_waddr = path_length[AW-1:0];
        buf_wdata = pred_rdata;
        if (accept && !start_bad) begin
            buf_we    = 1'b1;
            buf_waddr = '0;
            buf_wdata = destination;
        end else if (state == S_CHECK && !pred_none && !buf_full) begin
            buf_we    = 1'b1;
        end
    end

    // Buffer contents need no reset; only entries below path_length are read.
    always_ff @(posedge clock) begin
        if (buf_we) begin
            path_buf[buf_waddr] <= buf_wdata;
        end
    end

    // Read-out mapping. Arithmetic is done modulo the buffer depth; the
    // out-of-range case is caught by the path_length compare below.
    always_comb begin
`ifdef PATH_SOURCE_FIRST_EN
        rd_sel = AW'(path_length) - AW'(1) - AW'(path_index);
`else
        rd_sel = AW'(path_index);
`endif
        if (path_index >= path_length) begin
            path_node = NO_PRED;
        end else begin
            path_node = path_buf[rd_sel];
        end
    end

    // Walk FSM. pred_addr doubles as the current node register: it is loaded
    // with the node to look up on every entry into READ.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pred_addr   <= '0;
            pred_rd     <= 1'b0;
            path_length <= '0;
            ready       <= 1'b0;
            error       <= 1'b0;
            src_q       <= '0;
            n_q         <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        src_q <= source;
                        n_q   <= number_of_nodes;
                        ready <= 1'b0;
                        error <= 1'b0;
                        if (start_bad) begin
                            path_length <= '0;
                            ready       <= 1'b1;
                            error       <= 1'b1;
                            state       <= S_FAIL;
                        end else if (destination == source) begin
                            path_length <= NODE_WIDTH'(1);
                            ready       <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            path_length <= NODE_WIDTH'(1);
                            pred_addr   <= destination;
                            pred_rd     <= 1'b1;
                            state       <= S_READ;
                        end
                    end
                end

                S_READ: begin
                    pred_rd <= 1'b0;
                    state   <= S_CHECK;
                end

                S_CHECK: begin
                    if (pred_none || buf_full) begin
                        ready <= 1'b1;
                        error <= 1'b1;
                        state <= S_FAIL;
                    end else begin
                        path_length <= path_length + NODE_WIDTH'(1);
                        if (pred_rdata == src_q) begin
                            ready <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            pred_addr <= pred_rdata;
                            pred_rd   <= 1'b1;
                            state     <= S_READ;
                        end
                    end
                end

                default: begin
                    pred_rd <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dijkstra_path_extractor.sv
// -----------------------------------------------------------------------------
// tb_dijkstra_path_extractor
//
// Directed bench for dijkstra_path_extractor. The predecessor memory is a
// small behavioural model with one-cycle read latency. Expected paths are
// written out by hand as walk-order lists and mapped to the read-out order of
// the build (PATH_SOURCE_FIRST_EN or not).
// -----------------------------------------------------------------------------
module tb_dijkstra_path_extractor;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] source;
    logic [15:0] destination;
    logic [16:0] number_of_nodes;
    logic [15:0] pred_addr;
    logic        pred_rd;
    logic [15:0] pred_rdata;
    logic [15:0] path_index;
    logic [15:0] path_node;
    logic [15:0] path_length;
    logic        ready;
    logic        error;
    logic [2:0]  state_dbg;

`ifdef PATH_SOURCE_FIRST_EN
    localparam bit SRC_FIRST = 1'b1;
`else
    localparam bit SRC_FIRST = 1'b0;
`endif

    int checks = 0;
    int fails  = 0;

    logic [15:0] pred_mem [0:31];
    int          rd_count = 0;
    int          rd_base;
    logic [15:0] walk [0:31];
    int          walk_len;
    int          cyc;

    always #10 clock = ~clock;

    dijkstra_path_extractor dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .source          (source),
        .destination     (destination),
        .number_of_nodes (number_of_nodes),
        .pred_addr       (pred_addr),
        .pred_rd         (pred_rd),
        .pred_rdata      (pred_rdata),
        .path_index      (path_index),
        .path_node       (path_node),
        .path_length     (path_length),
        .ready           (ready),
        .error           (error),
        .state_dbg       (state_dbg)
    );

    // Predecessor memory: data for a strobed address appears the next cycle.
    always @(posedge clock) begin
        if (pred_rd) begin
            pred_rdata <= pred_mem[pred_addr[4:0]];
            rd_count   <= rd_count + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [16:0] n);
        source          = s;
        destination     = d;
        number_of_nodes = n;
        start           = 1'b1;
        tick();
        start           = 1'b0;
    endtask

    // Counts edges from the start edge (which counts as 1) until ready.
    task automatic wait_ready(input string tag, input int limit, output int n);
        n = 1;
        while (!ready && n < limit) begin
            tick();
            n++;
        end
        check({tag, "_ready_within_limit"}, 32'(ready), 32'd1);
    endtask

    task automatic check_path(input string tag);
        for (int i = 0; i < walk_len; i++) begin
            path_index = 16'(i);
            #1;
            check($sformatf("%s_node%0d", tag, i), 32'(path_node),
                  32'(SRC_FIRST ? walk[walk_len-1-i] : walk[i]));
        end
        path_index = 16'(walk_len);
        #1;
        check({tag, "_node_out_of_range"}, 32'(path_node), 32'hFFFF);
        path_index = 16'd0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) pred_mem[i] = 16'hFFFF;
    endtask

    // pred = {FFFF,0,1,2,3,4,5,6}: straight chain 7 -> 0.
    task automatic load_chain();
        clear_mem();
        for (int i = 1; i < 8; i++) pred_mem[i] = 16'(i - 1);
    endtask

    task automatic set_chain_walk();
        walk_len = 8;
        for (int i = 0; i < 8; i++) walk[i] = 16'(7 - i);
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b0;
        source          = '0;
        destination     = '0;
        number_of_nodes = '0;
        path_index      = '0;
        clear_mem();

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_pred_addr",   32'(pred_addr),   32'd0);
        check("rst_pred_rd",     32'(pred_rd),     32'd0);
        check("rst_path_length", 32'(path_length), 32'd0);
        check("rst_ready",       32'(ready),       32'd0);
        check("rst_error",       32'(error),       32'd0);
        reset = 1'b0;
        tick();

        // ---------------- 8-node chain, L=8 -> ready at edge 15 ----------------
        load_chain();
        rd_base = rd_count;
        do_start(16'd0, 16'd7, 17'd8);
        check("chain_first_rd_strobe", 32'(pred_rd), 32'd1);
        check("chain_first_rd_addr",   32'(pred_addr), 32'd7);
        repeat (13) tick();
        check("chain_ready_edge14", 32'(ready), 32'd0);
        tick();
        check("chain_ready_edge15", 32'(ready), 32'd1);
        check("chain_error",  32'(error),       32'd0);
        check("chain_length", 32'(path_length), 32'd8);
        check("chain_reads",  32'(rd_count - rd_base), 32'd7);
        set_chain_walk();
        check_path("chain");

        // ---------------- pred={FFFF,0,1,1,3,4,5,6}: path 7,6,5,4,3,1,0 ----------------
        clear_mem();
        pred_mem[1] = 16'd0; pred_mem[2] = 16'd1; pred_mem[3] = 16'd1; pred_mem[4] = 16'd3;
        pred_mem[5] = 16'd4; pred_mem[6] = 16'd5; pred_mem[7] = 16'd6;
        do_start(16'd0, 16'd7, 17'd8);
        repeat (11) tick();
        check("skip_ready_edge12", 32'(ready), 32'd0);
        tick();
        check("skip_ready_edge13", 32'(ready), 32'd1);
        check("skip_error",  32'(error),       32'd0);
        check("skip_length", 32'(path_length), 32'd7);
        walk_len = 7;
        walk[0] = 16'd7; walk[1] = 16'd6; walk[2] = 16'd5; walk[3] = 16'd4;
        walk[4] = 16'd3; walk[5] = 16'd1; walk[6] = 16'd0;
        check_path("skip");

        // ---------------- source == destination ----------------
        load_chain();
        rd_base = rd_count;
        do_start(16'd3, 16'd3, 17'd8);
        check("same_ready",  32'(ready),       32'd1);
        check("same_error",  32'(error),       32'd0);
        check("same_length", 32'(path_length), 32'd1);
        tick();
        check("same_no_reads", 32'(rd_count - rd_base), 32'd0);
        walk_len = 1;
        walk[0]  = 16'd3;
        check_path("same");

        // ---------------- unreachable: pred[5]=FFFF ----------------
        load_chain();
        pred_mem[5] = 16'hFFFF;
        do_start(16'd0, 16'd5, 17'd8);
        check("unreach_ready_cleared_by_start", 32'(ready), 32'd0);
        tick();
        check("unreach_ready_edge2", 32'(ready), 32'd0);
        tick();
        check("unreach_ready_edge3", 32'(ready),       32'd1);
        check("unreach_error",       32'(error),       32'd1);
        check("unreach_length",      32'(path_length), 32'd1);
        walk_len = 1;
        walk[0]  = 16'd5;
        check_path("unreach");

        // ---------------- cycle in predecessor table ----------------
        clear_mem();
        pred_mem[1] = 16'd2;
        pred_mem[2] = 16'd1;
        do_start(16'd0, 16'd1, 17'd8);
        wait_ready("cycle", 60, cyc);
        check("cycle_latency", 32'(cyc),         32'd17);
        check("cycle_error",   32'(error),       32'd1);
        check("cycle_length",  32'(path_length), 32'd8);

        // ---------------- argument errors ----------------
        load_chain();
        rd_base = rd_count;
        do_start(16'd0, 16'd9, 17'd8);
        check("dst_oob_ready",  32'(ready),       32'd1);
        check("dst_oob_error",  32'(error),       32'd1);
        check("dst_oob_length", 32'(path_length), 32'd0);
        tick();
        check("dst_oob_no_reads", 32'(rd_count - rd_base), 32'd0);

        do_start(16'd8, 16'd2, 17'd8);
        check("src_oob_error", 32'(error), 32'd1);
        do_start(16'd0, 16'd1, 17'd33);
        check("n_too_big_error", 32'(error), 32'd1);
        do_start(16'd0, 16'd0, 17'd0);
        check("n_zero_error", 32'(error), 32'd1);
        do_start(16'd0, 16'd0, 17'd32);
        check("n_max_ok_error",  32'(error), 32'd0);
        check("n_max_ok_ready",  32'(ready), 32'd1);

        // ---------------- reset mid-walk ----------------
        load_chain();
        do_start(16'd0, 16'd7, 17'd8);
        tick();
        check("mid_in_check", 32'(state_dbg), 32'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_ready",   32'(ready),       32'd0);
        check("mid_rst_length",  32'(path_length), 32'd0);
        check("mid_rst_pred_rd", 32'(pred_rd),     32'd0);
        check("mid_rst_state",   32'(state_dbg),   32'd0);
        tick();
        reset = 1'b0;
        tick();

        // ---------------- full run after reset, start during READ ignored ----------------
        rd_base = rd_count;
        do_start(16'd0, 16'd7, 17'd8);
        check("restart_in_read", 32'(state_dbg), 32'd1);
        source      = 16'd0;
        destination = 16'd3;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        repeat (12) tick();
        check("restart_ready_edge14", 32'(ready), 32'd0);
        tick();
        check("restart_ready_edge15", 32'(ready),       32'd1);
        check("restart_error",        32'(error),       32'd0);
        check("restart_length",       32'(path_length), 32'd8);
        check("restart_reads",        32'(rd_count - rd_base), 32'd7);
        set_chain_walk();
        check_path("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
